stream_sum_max_accum: RTL and testbench

//   Frame-based streaming arithmetic unit. Each beat carries an operand pair (a,b).

---
 rtl/stream_sum_max_accum.sv | 144 ++++++++++++++
 tb/tb_stream_sum_max_accum.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/stream_sum_max_accum.sv
// Frame-based streaming unit: accumulates saturated sum of (a+b), the running max of a/b
// and a saturating beat count per frame, then presents the result with a valid/ready handshake.
module stream_sum_max_accum #(
    parameter int W      = 8,
    parameter int ACC_W  = 16,
    parameter int CNT_W  = 8,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [W-1:0]     out_max,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat
);

    localparam int XW = ACC_W + 2;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t state, state_nx;

    logic [ACC_W-1:0] acc_sum;
    logic [W-1:0]     run_max;
    logic [CNT_W-1:0] cnt;
    logic             sat_run;

    logic             beat_acc;
    logic [W:0]       s_beat;
    logic [W-1:0]     m_beat;
    logic [ACC_W:0]   add_res;
    logic [ACC_W-1:0] sum_nx;
    logic [W-1:0]     max_nx;
    logic [CNT_W-1:0] cnt_nx;
    logic             sat_nx;

    function automatic logic gt(input logic [W-1:0] x, input logic [W-1:0] y);
        if (SIGNED != 0)
            return $signed(x) > $signed(y);
        else
            return x > y;
    endfunction

    function automatic logic [W:0] beat_sum(input logic [W-1:0] a, input logic [W-1:0] b);
        if (SIGNED != 0)
            return {a[W-1], a} + {b[W-1], b};
        else
            return {1'b0, a} + {1'b0, b};
    endfunction

    // Returns {clamped, value}; the sum is formed two bits wider so it never wraps before clamping.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc, input logic [W:0] s);
        logic signed [XW-1:0] ax, sx, tot, maxv, minv;
        if (SIGNED != 0) begin
            ax   = {{2{acc[ACC_W-1]}}, acc};
            sx   = {{(XW-W-1){s[W]}}, s};
            maxv = (XW'(1) << (ACC_W-1)) - XW'(1);
            minv = -(XW'(1) << (ACC_W-1));
        end else begin
            ax   = {2'b00, acc};
            sx   = {{(XW-W-1){1'b0}}, s};
            maxv = (XW'(1) << ACC_W) - XW'(1);
            minv = '0;
        end
        tot = ax + sx;
        if (tot > maxv)
            return {1'b1, maxv[ACC_W-1:0]};
        else if (tot < minv)
            return {1'b1, minv[ACC_W-1:0]};
        else
            return {1'b0, tot[ACC_W-1:0]};
    endfunction

    assign in_ready  = (state != DONE);
    assign out_valid = (state == DONE);
    assign beat_acc  = in_valid && in_ready;

    always_comb begin
        s_beat  = beat_sum(in_a, in_b);
        m_beat  = gt(in_b, in_a) ? in_b : in_a;
        add_res = sat_add(acc_sum, s_beat);
        sum_nx  = add_res[ACC_W-1:0];
        if (state == IDLE)
            max_nx = m_beat;
        else
            max_nx = gt(m_beat, run_max) ? m_beat : run_max;
        cnt_nx = (cnt == '1) ? cnt : cnt + CNT_W'(1);
        sat_nx = sat_run | add_res[ACC_W] | (cnt == '1);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, ACCUM: if (beat_acc) state_nx = in_last ? DONE : ACCUM;
            DONE:        if (out_ready) state_nx = IDLE;
            default:     state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Frame accumulators clear as the result is captured, so IDLE always starts from zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_sum   <= '0;
            run_max   <= '0;
            cnt       <= '0;
            sat_run   <= 1'b0;
            out_sum   <= '0;
            out_max   <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
        end else if (beat_acc) begin
            if (in_last) begin
                out_sum   <= sum_nx;
                out_max   <= max_nx;
                out_count <= cnt_nx;
                out_sat   <= sat_nx;
                acc_sum   <= '0;
                run_max   <= '0;
                cnt       <= '0;
                sat_run   <= 1'b0;
            end else begin
                acc_sum   <= sum_nx;
                run_max   <= max_nx;
                cnt       <= cnt_nx;
                sat_run   <= sat_nx;
            end
        end
    end

endmodule

// File: tb/tb_stream_sum_max_accum.sv
// Directed bench: three instances (unsigned 16-bit acc, signed 16-bit acc, unsigned 10-bit acc)
// share one input stream; each test checks the instance whose configuration it targets.
module tb_stream_sum_max_accum;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;

    logic        rdy_u, rdy_s, rdy_n;
    logic        vld_u, vld_s, vld_n;
    logic [15:0] sum_u, sum_s;
    logic [9:0]  sum_n;
    logic [7:0]  max_u, max_s, max_n;
    logic [7:0]  cnt_u, cnt_s, cnt_n;
    logic        sat_u, sat_s, sat_n;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stream_sum_max_accum #(.W(8), .ACC_W(16), .CNT_W(8), .SIGNED(0)) u_uns (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_u),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(vld_u),
        .out_ready(out_ready), .out_sum(sum_u), .out_max(max_u),
        .out_count(cnt_u), .out_sat(sat_u));

    stream_sum_max_accum #(.W(8), .ACC_W(16), .CNT_W(8), .SIGNED(1)) u_sgn (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_s),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(vld_s),
        .out_ready(out_ready), .out_sum(sum_s), .out_max(max_s),
        .out_count(cnt_s), .out_sat(sat_s));

    stream_sum_max_accum #(.W(8), .ACC_W(10), .CNT_W(8), .SIGNED(0)) u_nar (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_n),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(vld_n),
        .out_ready(out_ready), .out_sum(sum_n), .out_max(max_n),
        .out_count(cnt_n), .out_sat(sat_n));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input logic last);
        logic taken;
        taken = 1'b0;
        in_a = a;
        in_b = b;
        in_last = last;
        in_valid = 1'b1;
        for (int k = 0; k < 20 && !taken; k++) begin
            taken = rdy_u;
            tick();
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        check("beat_accept", {31'd0, taken}, 32'd1);
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("handoff_vld", {31'd0, vld_u}, 32'd0);
    endtask

    initial begin
        // 1: reset state
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_vld", {31'd0, vld_u}, 32'd0);
        check("rst_rdy", {31'd0, rdy_u}, 32'd1);
        check("rst_sum", {16'd0, sum_u}, 32'd0);
        check("rst_max", {24'd0, max_u}, 32'd0);
        check("rst_cnt", {24'd0, cnt_u}, 32'd0);
        check("rst_sat", {31'd0, sat_u}, 32'd0);

        // 2: unsigned two-beat frame
        send_beat(8'd10, 8'd20, 1'b0);
        send_beat(8'd200, 8'd100, 1'b1);
        check("t2_vld", {31'd0, vld_u}, 32'd1);
        check("t2_sum", {16'd0, sum_u}, 32'd330);
        check("t2_max", {24'd0, max_u}, 32'd200);
        check("t2_cnt", {24'd0, cnt_u}, 32'd2);
        check("t2_sat", {31'd0, sat_u}, 32'd0);

        // 5: backpressure holds the result and blocks input
        in_valid = 1'b1;
        in_a = 8'd1;
        in_b = 8'd2;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_rdy", {31'd0, rdy_u}, 32'd0);
            check("bp_vld", {31'd0, vld_u}, 32'd1);
            check("bp_sum", {16'd0, sum_u}, 32'd330);
            check("bp_max", {24'd0, max_u}, 32'd200);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("bp_done_vld", {31'd0, vld_u}, 32'd0);
        check("bp_done_rdy", {31'd0, rdy_u}, 32'd1);
        check("bp_hold_sum", {16'd0, sum_u}, 32'd330);
        tick();
        check("bp_no_beat", {31'd0, vld_u}, 32'd0);

        // 3: signed frame (also seen unsigned by the other instance)
        send_beat(8'hFB, 8'h03, 1'b0);
        send_beat(8'h80, 8'hFF, 1'b1);
        check("t3_vld", {31'd0, vld_s}, 32'd1);
        check("t3_sum", {16'd0, sum_s}, 32'h0000FF7D);
        check("t3_max", {24'd0, max_s}, 32'd3);
        check("t3_cnt", {24'd0, cnt_s}, 32'd2);
        check("t3_sat", {31'd0, sat_s}, 32'd0);
        check("t3_usum", {16'd0, sum_u}, 32'd637);
        check("t3_umax", {24'd0, max_u}, 32'd255);
        handoff();

        // 4: accumulator saturation on the 10-bit instance
        for (int i = 0; i < 5; i++)
            send_beat(8'd255, 8'd255, i == 4);
        check("t4_sum", {22'd0, sum_n}, 32'd1023);
        check("t4_sat", {31'd0, sat_n}, 32'd1);
        check("t4_cnt", {24'd0, cnt_n}, 32'd5);
        check("t4_max", {24'd0, max_n}, 32'd255);
        check("t4_wsum", {16'd0, sum_u}, 32'd2550);
        check("t4_wsat", {31'd0, sat_u}, 32'd0);
        check("t4_ssum", {16'd0, sum_s}, 32'h0000FFF6);
        check("t4_smax", {24'd0, max_s}, 32'h000000FF);
        handoff();

        // count saturation: 256 beats with an 8-bit counter
        for (int i = 0; i < 256; i++)
            send_beat(8'd0, 8'd0, i == 255);
        check("cnt_sat_cnt", {24'd0, cnt_u}, 32'd255);
        check("cnt_sat_flag", {31'd0, sat_u}, 32'd1);
        check("cnt_sat_sum", {16'd0, sum_u}, 32'd0);
        handoff();

        // 6: reset mid-frame discards the partial frame
        send_beat(8'd50, 8'd60, 1'b0);
        send_beat(8'd50, 8'd60, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6_rst_vld", {31'd0, vld_u}, 32'd0);
        check("t6_rst_sum", {16'd0, sum_u}, 32'd0);
        send_beat(8'd7, 8'd9, 1'b1);
        check("t6_vld", {31'd0, vld_u}, 32'd1);
        check("t6_sum", {16'd0, sum_u}, 32'd16);
        check("t6_max", {24'd0, max_u}, 32'd9);
        check("t6_cnt", {24'd0, cnt_u}, 32'd1);
        check("t6_sat", {31'd0, sat_u}, 32'd0);
        handoff();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
